// File: rtl/mips_disp_pkg.sv
// Shared seven-segment constants, hex decode and display-state type for mips_trace_display.
package mips_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        LIVE   = 1'b0,
        BROWSE = 1'b1
    } disp_state_t;

    // Active-low segments, bit6 = a ... bit0 = g.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/mips_trace_display_key_debounce.sv
// Push-key conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// press pulse on each accepted released-to-pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_level & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/mips_trace_display.sv
// Six-digit PC/WD trace display with optional history browser (TRACE_HISTORY_EN):
// ring buffer of {PC[7:0], WD[15:0]} samples, debounced prev/next keys, LIVE/BROWSE FSM.
module mips_trace_display
    import mips_disp_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              PC_val,
    input  logic [31:0]              WD_val,
    input  logic                     capture_en,
    input  logic                     key_prev,
    input  logic                     key_next,
    output logic [6:0]               HEX5,
    output logic [6:0]               HEX4,
    output logic [6:0]               HEX3,
    output logic [6:0]               HEX2,
    output logic [6:0]               HEX1,
    output logic [6:0]               HEX0,
    output logic                     live,
    output logic [$clog2(DEPTH)-1:0] hist_off
);
    localparam int AW = $clog2(DEPTH);

    logic [23:0] w_live_entry;
    logic [23:0] w_src;
    logic [6:0]  w_hex [6];
    logic        w_unused;

    assign w_live_entry = {PC_val[7:0], WD_val[15:0]};

`ifdef TRACE_HISTORY_EN
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_hist_off;
    logic [AW:0]   r_count;
    disp_state_t   r_state;
    logic          w_press_prev;
    logic          w_press_next;
    logic          w_prev;
    logic          w_next;
    logic          w_push;
    logic [AW-1:0] w_rd_addr;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clock (clock),
        .reset (reset),
        .key_n (key_prev),
        .press (w_press_prev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clock (clock),
        .reset (reset),
        .key_n (key_next),
        .press (w_press_next)
    );

    // Coincident presses cancel each other.
    assign w_prev    = w_press_prev & ~w_press_next;
    assign w_next    = w_press_next & ~w_press_prev;
    assign w_push    = (r_state == LIVE) && capture_en;
    assign w_rd_addr = r_wp - AW'(1) - r_hist_off;

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wp] <= w_live_entry;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= LIVE;
            r_hist_off <= '0;
            r_wp       <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
                if (r_count != CNT_FULL)
                    r_count <= r_count + (AW+1)'(1);
            end
            case (r_state)
                LIVE: begin
                    if (w_prev && (r_count != '0)) begin
                        r_state    <= BROWSE;
                        r_hist_off <= '0;
                    end
                end
                BROWSE: begin
                    if (w_prev) begin
                        if ({1'b0, r_hist_off} < (r_count - (AW+1)'(1)))
                            r_hist_off <= r_hist_off + AW'(1);
                    end else if (w_next) begin
                        if (r_hist_off != '0)
                            r_hist_off <= r_hist_off - AW'(1);
                        else
                            r_state <= LIVE;
                    end
                end
                default: r_state <= LIVE;
            endcase
        end
    end

    assign w_src    = (r_state == BROWSE) ? r_mem[w_rd_addr] : w_live_entry;
    assign live     = (r_state == LIVE);
    assign hist_off = r_hist_off;
    assign w_unused = ^{PC_val[31:8], WD_val[31:16]};
`else
    assign w_src    = w_live_entry;
    assign live     = 1'b1;
    assign hist_off = '0;
    assign w_unused = ^{PC_val[31:8], WD_val[31:16], capture_en, key_prev, key_next};
`endif

    // Digit gi shows nibble gi of the selected entry; blank until the first edge after reset.
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        logic [6:0] r_seg;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)
                r_seg <= SEG_BLANK;
            else
                r_seg <= hex7seg(w_src[gi*4 +: 4]);
        end
        assign w_hex[gi] = r_seg;
    end

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];

endmodule
